// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronised rx, mid-bit sampling, one-cycle data_valid / frame_err pulses.
// The stop sample is registered before the output update, so both pulses appear one cycle after it.
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       data_valid,
  output logic       frame_err
);

  localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CNT = BIT_CNT / 2;
  localparam int unsigned CW       = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            stop_hit_q, stop_bit_q;
  logic [7:0]      data_q;
  logic            valid_q, err_q;

  logic            fall;
  logic            half_end;
  logic            bit_end;
  logic            sample_stop;

  assign fall     = rx_prev_q & ~rx_sync_q;
  assign half_end = (cnt_q == CW'(HALF_CNT - 1));
  assign bit_end  = (cnt_q == CW'(BIT_CNT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      stop_hit_q <= 1'b0;
      stop_bit_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      stop_hit_q <= sample_stop;
      stop_bit_q <= rx_sync_q;
      valid_q    <= stop_hit_q & stop_bit_q;
      err_q      <= stop_hit_q & ~stop_bit_q;
      if (stop_hit_q && stop_bit_q) begin
        data_q <= shift_q;
      end
    end
  end

  // Leaving STOP at mid-bit lets the next start edge of a back-to-back frame be seen.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall) state_d = START;
      START: if (half_end) state_d = rx_sync_q ? IDLE : DATA;
      DATA:  if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
      STOP:  if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    sample_stop = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      START: begin
        cnt_d = half_end ? '0 : cnt_q + CW'(1);
      end
      DATA: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d       = '0;
          sample_stop = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign data_o     = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: doc/uart_rx_byte.md
UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge; one clock domain only.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1 frames, LSB first.
REQ-006 SHALL have port data_o  output  8  last correctly framed byte; this is the ASCII code fed to the downstream digit decoder.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse; data_o is newly updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse; the stop bit was sampled low.

Function
REQ-009 SHALL pass rx through a 2-flop synchroniser (both flops reset to 1) before any use.
REQ-010 SHALL derive BIT_CNT = CLK_FREQ/BAUD (integer division) and HALF_CNT = BIT_CNT/2.
REQ-011 SHALL implement the states IDLE, START, DATA and STOP.
REQ-012 IDLE -> START SHALL occur on a falling edge of the synchronised rx (previous 1, current 0); the baud counter clears at that point.
REQ-013 In START, at baud count HALF_CNT-1, the FSM SHALL go to DATA if synchronised rx = 0; otherwise it SHALL return to IDLE (false start, no output pulse).
REQ-014 In DATA, the FSM SHALL sample 8 bits, one every BIT_CNT cycles from the mid-start point, shifting LSB first into an internal shift register; a 3-bit bit index counts 0..7, and after bit 7 the FSM goes to STOP.
REQ-015 In STOP, the FSM SHALL sample once at mid-bit (BIT_CNT cycles after the bit-7 sample).
- If rx = 1: load data_o from the shift register and pulse data_valid in the following cycle.
- If rx = 0: pulse frame_err in the following cycle; data_o is left unchanged.
REQ-016 After the stop sample, the FSM SHALL enter IDLE immediately (half a bit early) so that back-to-back frames with one stop bit are received.
REQ-017 A line held low after a framing error SHALL NOT retrigger reception; a new start needs a fresh 1->0 edge.
REQ-018 data_valid and frame_err SHALL each be high for exactly one cycle per frame, SHALL never be high together, and SHALL be low in every other cycle.
REQ-019 data_o SHALL hold its value between data_valid pulses.
REQ-020 The baud counter SHALL be wide enough for BIT_CNT-1 and SHALL never wrap within a bit period.
REQ-021 Latency: data_valid SHALL rise 2 (synchroniser) + 1 (edge detect) + HALF_CNT + 9*BIT_CNT + 1 cycles (±1) after the rx falling edge at the pin.
REQ-022 rx transitions in the DATA and STOP states SHALL NOT affect timing; only the mid-bit samples are used.

Reset
REQ-023 While rst_n = 0 at a clock edge:
- state = IDLE
- baud counter, bit index and shift register = 0
- data_o = 8'h00
- data_valid = 0, frame_err = 0
- synchroniser flops = 1
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL resume only on the next falling edge.

Verification (CLK_FREQ=50_000_000, BAUD=115200, BIT_CNT=434)
REQ-025 Drive frame 0x35 ('5') with a valid stop bit -> one data_valid pulse, data_o = 8'h35, frame_err stays 0.
REQ-026 Drive back-to-back frames 0x31, 0x32, 0x3A ("12:") with no idle gap -> three data_valid pulses in order with data_o = 31, 32, 3A; pulse spacing 4340 ±2 cycles.
REQ-027 Drive a 100-cycle low glitch on an idle line -> no data_valid, no frame_err, FSM back in IDLE by cycle HALF_CNT+4.
REQ-028 Drive frame 0x2F with stop bit = 0, then hold rx low for 20 bit times -> exactly one frame_err pulse, data_o keeps its previous value, no further pulses until rx goes high and falls again.
REQ-029 Assert rst_n = 0 for 3 cycles during data bit 4 of frame 0x39, then send 0x30 -> no output for the aborted frame, then data_valid with data_o = 8'h30.
REQ-030 Observe outputs after power-up reset -> data_o = 8'h00, data_valid = 0, frame_err = 0 until the first complete frame.
